// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared types and constants for the pipeline hazard/stall unit.
package hazard_stall_unit_pkg;
  typedef enum logic [1:0] {NONE = 2'b00, LOAD_USE = 2'b01, BRANCH = 2'b10, MULDIV = 2'b11} stall_cause_t;
  typedef enum logic [1:0] {RUN, DATA, MDW} fsm_state_t;
  localparam logic [63:0] STALL_CNT_MAX = '1;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: ID/EX/MEM hazard inputs and stall/flush controls of the hazard unit.
interface hazard_stall_unit_if #(parameter int LRA = 5, parameter int LSC = 32);
  logic [LRA-1:0] reg_1_id, reg_2_id, reg_3_ex, reg_3_m;
  logic uses_1_id, uses_2_id, branch_id, branch_taken_id, muldiv_id, hilo_read_id;
  logic reg_write_ex, mem_read_ex, muldiv_start_ex, mem_read_m, clear_stats;
  logic stall_pc, stall_if_id, bubble_ex, flush_if_id, muldiv_busy, muldiv_done;
  logic [1:0] stall_cause;
  logic [LSC-1:0] stall_cycles;
  modport master (
    output reg_1_id, reg_2_id, uses_1_id, uses_2_id, branch_id, branch_taken_id, muldiv_id,
           hilo_read_id, reg_3_ex, reg_write_ex, mem_read_ex, muldiv_start_ex, reg_3_m,
           mem_read_m, clear_stats,
    input  stall_pc, stall_if_id, bubble_ex, flush_if_id, muldiv_busy, muldiv_done,
           stall_cause, stall_cycles
  );
  modport slave (
    input  reg_1_id, reg_2_id, uses_1_id, uses_2_id, branch_id, branch_taken_id, muldiv_id,
           hilo_read_id, reg_3_ex, reg_write_ex, mem_read_ex, muldiv_start_ex, reg_3_m,
           mem_read_m, clear_stats,
    output stall_pc, stall_if_id, bubble_ex, flush_if_id, muldiv_busy, muldiv_done,
           stall_cause, stall_cycles
  );
endinterface

// File: rtl/muldiv_busy_counter.sv
// muldiv_busy_counter: tracks how many more EX cycles a mult/div keeps HI/LO busy.
module muldiv_busy_counter #(parameter int MULDIV_LATENCY = 4) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done
);
  logic [3:0] cnt;
  // a start while busy cannot happen in a correct pipeline and is dropped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (start && cnt == '0) cnt <= 4'(MULDIV_LATENCY - 1);
    else if (cnt != '0) cnt <= cnt - 4'd1;
  assign busy = cnt != '0;
  assign done = cnt == 4'd1;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: detects load-use, branch-operand and mult/div hazards forwarding cannot cover,
// and drives PC/IF-ID hold, ID-EX bubble, IF-ID flush and a saturating stall-cycle counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LEN_REG_FILE_ADDR = 5,
  parameter int MULDIV_LATENCY    = 4,
  parameter int LEN_STALL_CNT     = 32
) (
  input logic clk,
  input logic reset_n,
  hazard_stall_unit_if.slave hz
);
  logic busy, done, load_use, br_ex, br_ld_m, md_haz, data_stall, stall;
  fsm_state_t state, state_nxt;
  stall_cause_t cause;
  logic [LEN_STALL_CNT-1:0] cnt;
  function automatic logic src_hit(input logic [LEN_REG_FILE_ADDR-1:0] r, a, b, input logic ua, ub);
    return r != '0 && ((r == a && ua) || (r == b && ub));
  endfunction
  muldiv_busy_counter #(.MULDIV_LATENCY(MULDIV_LATENCY)) u_md (
    .clk(clk), .reset_n(reset_n), .start(hz.muldiv_start_ex), .busy(busy), .done(done)
  );
  assign load_use   = hz.mem_read_ex && src_hit(hz.reg_3_ex, hz.reg_1_id, hz.reg_2_id, hz.uses_1_id, hz.uses_2_id);
  assign br_ex      = hz.branch_id && hz.reg_write_ex && src_hit(hz.reg_3_ex, hz.reg_1_id, hz.reg_2_id, hz.uses_1_id, hz.uses_2_id);
  assign br_ld_m    = hz.branch_id && hz.mem_read_m && src_hit(hz.reg_3_m, hz.reg_1_id, hz.reg_2_id, hz.uses_1_id, hz.uses_2_id);
  assign md_haz     = busy && (hz.hilo_read_id || hz.muldiv_id);
  assign data_stall = load_use || br_ex || br_ld_m;
  assign stall      = md_haz || data_stall;
  // a load feeding a branch is reported as a branch stall, so the two-cycle sequence reads 10, 10
  assign cause = md_haz ? MULDIV : (br_ex || br_ld_m) ? BRANCH : load_use ? LOAD_USE : NONE;
  assign hz.stall_pc     = reset_n && stall;
  assign hz.stall_if_id  = reset_n && stall;
  assign hz.bubble_ex    = reset_n && stall;
  assign hz.flush_if_id  = reset_n && hz.branch_taken_id && !stall;
  assign hz.muldiv_busy  = reset_n && busy;
  assign hz.muldiv_done  = reset_n && done;
  assign hz.stall_cause  = reset_n ? cause : NONE;
  assign hz.stall_cycles = cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == MDW && done) ? RUN : md_haz ? MDW : data_stall ? DATA : RUN;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (hz.clear_stats) cnt <= '0;
    else if (stall && cnt != STALL_CNT_MAX[LEN_STALL_CNT-1:0]) cnt <= cnt + 1'b1;
endmodule
